comp_monitor_4bit: RTL and testbench
====================================

Name: comp_monitor_4bit

Overview:
- Sequential stage directly downstream of the 4-bit comparator.
- Samples the comparator flags IG/MA/ME on an enable strobe and keeps saturating event counters per result.
- Detects a stable "equal" condition over STABLE_N consecutive samples and raises TRAVA (lock).
- Flags illegal flag combinations (ERRO) and pulses on every change of result (MUDOU).

Parameters:
- CNT_W, 8, width of each event counter.
- STABLE_N, 4, consecutive IG samples required to assert TRAVA; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- HAB  input  1  sample enable; flags are sampled on the rising CLK edge where HAB=1.
- CLR  input  1  synchronous clear; has priority over HAB.
- IG  input  1  comparator equal flag.
- MA  input  1  comparator greater flag (A>B).
- ME  input  1  comparator less flag (A<B).
- CNT_IG  output  CNT_W  count of valid IG samples.
- CNT_MA  output  CNT_W  count of valid MA samples.
- CNT_ME  output  CNT_W  count of valid ME samples.
- TRAVA  output  1  equal condition has been stable for at least STABLE_N samples.
- ERRO  output  1  sticky flag: an illegal flag combination was sampled.
- MUDOU  output  1  one-cycle pulse: the latest valid result differs from the previous valid result.

Behaviour:
- Reset: one clock CLK; reset is asynchronous and active-low on RST_N. While RST_N=0, all outputs are 0, FSM is in OCIOSO, run counter is 0, last-code register is NONE.
- Outputs are registered. Every effect of a sample is visible in the cycle after the sampling edge (latency 1).
- Valid sample: HAB=1 and {IG,MA,ME} is exactly one-hot. Any other combination with HAB=1 is an invalid sample.
- HAB=0: all state holds and MUDOU=0.
- Counters:
  - A valid sample increments only the matching counter.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - An invalid sample leaves all counters unchanged.
- ERRO: set by any invalid sample; stays set until CLR or reset.
- Last code: 2-bit register, NONE=00, ME=01, MA=10, IG=11. Updated on every valid sample.
- MUDOU:
  - Pulses for one cycle when a valid sample's code differs from last code and last code is not NONE.
  - No pulse on the first valid sample after reset or CLR.
  - Invalid samples never pulse MUDOU and leave last code unchanged.
- Stability FSM (4-bit run counter RUN):
  - OCIOSO: RUN=0, TRAVA=0. A valid IG sample sets RUN=1 and goes to CONTANDO; if STABLE_N=1 it goes directly to TRAVADO.
  - CONTANDO: a valid IG sample increments RUN; when the new RUN equals STABLE_N, go to TRAVADO. A valid MA/ME sample or an invalid sample goes to OCIOSO with RUN=0.
  - TRAVADO: TRAVA=1. Valid IG samples keep the state; RUN holds at STABLE_N. A valid MA/ME sample or an invalid sample goes to OCIOSO and TRAVA=0 in the next cycle.
- CLR=1 (synchronous):
  - Zeroes counters, ERRO, MUDOU and RUN; sets last code to NONE; FSM to OCIOSO.
  - Any sample taken in the same cycle is ignored.
- Reset asserted mid-run: immediate return to reset values, independent of CLK.

Optional Feature:
- Macro HIST_EN.
- Defined:
  - Adds output HIST, 8 bits: shift register of the last four valid codes, using the last-code encoding.
  - Newest code in HIST[1:0]; older codes shift toward HIST[7:6] on each valid sample.
  - Reset and CLR set HIST to 0. Invalid samples and HAB=0 do not shift.
- Not defined: HIST port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 valid MA samples (HAB=1, MA=1) -> CNT_MA=3, CNT_IG=0, CNT_ME=0, ERRO=0, MUDOU never 1, TRAVA=0.
- STABLE_N=4, feed IG, IG, IG, IG -> TRAVA=1 exactly one cycle after the 4th sampling edge. Then one ME sample -> TRAVA=0 the next cycle, CNT_ME=1.
- IG, IG, MA, IG, IG, IG (STABLE_N=4) -> TRAVA stays 0 throughout. MUDOU pulses twice: after MA and after the following IG.
- IG=1 and MA=1 together with HAB=1 -> ERRO=1 and remains 1 through later valid samples. Counters unchanged by that sample. FSM returns to OCIOSO. CLR -> ERRO=0.
- CNT_W=3, 10 valid ME samples -> CNT_ME saturates at 7. CLR asserted with HAB=1 and ME=1 in the same cycle -> CNT_ME=0 and the sample is ignored.
- With HIST_EN defined, feed ME, MA, IG, IG -> HIST=8'b01101111. Assert RST_N=0 mid-cycle -> all outputs and HIST go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/comp_monitor_4bit.sv
// Purpose : samples comparator flags IG/MA/ME on HAB, counts results, detects stable equality (TRAVA).
// Latency : 1 cycle from the sampling edge to every registered output.
// Backpress: none; a sample is taken on every edge with HAB=1, and CLR overrides any sample.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   HAB, CLR            sample enable, synchronous clear (priority over HAB)
//   IG, MA, ME          comparator flags: equal, greater, less
//   CNT_IG/MA/ME        saturating event counters, CNT_W bits each
//   TRAVA               equal condition stable for at least STABLE_N samples
//   ERRO                sticky: a non-one-hot flag set was sampled
//   MUDOU               one-cycle pulse when a valid result differs from the previous one
//   HIST                (only with HIST_EN defined) last four valid codes, newest in [1:0]
// Optional feature macro: HIST_EN
module comp_monitor_4bit #(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 4   // legal range 1..15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HAB,
  input  logic             CLR,
  input  logic             IG,
  input  logic             MA,
  input  logic             ME,
  output logic [CNT_W-1:0] CNT_IG,
  output logic [CNT_W-1:0] CNT_MA,
  output logic [CNT_W-1:0] CNT_ME,
  output logic             TRAVA,
  output logic             ERRO,
  output logic             MUDOU
`ifdef HIST_EN
  ,
  output logic [7:0]       HIST
`endif
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    TRAVADO  = 2'd2
  } state_t;

  localparam logic [1:0]       CODE_NONE  = 2'b00;
  localparam logic [1:0]       CODE_ME    = 2'b01;
  localparam logic [1:0]       CODE_MA    = 2'b10;
  localparam logic [1:0]       CODE_IG    = 2'b11;
  localparam logic [3:0]       STABLE_LIM = 4'(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             w_onehot;
  logic             w_valid;
  logic             w_valid_ig;
  logic [1:0]       w_code;
  logic [3:0]       w_run_inc;
  state_t           w_state_nxt;
  logic [3:0]       w_run_nxt;

  state_t           r_state;
  logic [3:0]       r_run;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt_ig;
  logic [CNT_W-1:0] r_cnt_ma;
  logic [CNT_W-1:0] r_cnt_me;
  logic             r_erro;
  logic             r_mudou;

  // Odd parity rules out 0 and 2 flags set; the AND term rules out all three.
  assign w_onehot   = (IG ^ MA ^ ME) & ~(IG & MA & ME);
  assign w_valid    = HAB & w_onehot;
  assign w_valid_ig = w_valid & IG;
  assign w_code     = IG ? CODE_IG : (MA ? CODE_MA : CODE_ME);
  assign w_run_inc  = r_run + 4'd1;

  // Stability FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= OCIOSO;
      r_run   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Stability FSM: next state. Any sample that is not a valid IG breaks the run.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (CLR) begin
      w_state_nxt = OCIOSO;
      w_run_nxt   = 4'd0;
    end else if (w_valid_ig) begin
      case (r_state)
        OCIOSO: begin
          w_run_nxt   = 4'd1;
          w_state_nxt = (STABLE_LIM == 4'd1) ? TRAVADO : CONTANDO;
        end
        CONTANDO: begin
          w_run_nxt = w_run_inc;
          if (w_run_inc == STABLE_LIM) begin
            w_state_nxt = TRAVADO;
          end
        end
        TRAVADO: begin
          w_run_nxt   = r_run;
          w_state_nxt = TRAVADO;
        end
        default: begin
          w_run_nxt   = 4'd0;
          w_state_nxt = OCIOSO;
        end
      endcase
    end else if (HAB) begin
      w_state_nxt = OCIOSO;
      w_run_nxt   = 4'd0;
    end
  end

  // Counters, sticky error, last code and change pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt_ig <= '0;
      r_cnt_ma <= '0;
      r_cnt_me <= '0;
      r_erro   <= 1'b0;
      r_mudou  <= 1'b0;
      r_last   <= CODE_NONE;
    end else if (CLR) begin
      r_cnt_ig <= '0;
      r_cnt_ma <= '0;
      r_cnt_me <= '0;
      r_erro   <= 1'b0;
      r_mudou  <= 1'b0;
      r_last   <= CODE_NONE;
    end else begin
      r_mudou <= 1'b0;
      if (w_valid) begin
        r_last  <= w_code;
        r_mudou <= (r_last != CODE_NONE) && (r_last != w_code);
        case (w_code)
          CODE_IG: if (r_cnt_ig != CNT_MAX) r_cnt_ig <= r_cnt_ig + 1'b1;
          CODE_MA: if (r_cnt_ma != CNT_MAX) r_cnt_ma <= r_cnt_ma + 1'b1;
          default: if (r_cnt_me != CNT_MAX) r_cnt_me <= r_cnt_me + 1'b1;
        endcase
      end else if (HAB) begin
        r_erro <= 1'b1;
      end
    end
  end

`ifdef HIST_EN
  logic [7:0] r_hist;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hist <= 8'd0;
    end else if (CLR) begin
      r_hist <= 8'd0;
    end else if (w_valid) begin
      r_hist <= {r_hist[5:0], w_code};
    end
  end

  assign HIST = r_hist;
`endif

  assign CNT_IG = r_cnt_ig;
  assign CNT_MA = r_cnt_ma;
  assign CNT_ME = r_cnt_me;
  assign TRAVA  = (r_state == TRAVADO);
  assign ERRO   = r_erro;
  assign MUDOU  = r_mudou;

endmodule

// File: tb/tb_comp_monitor_4bit.sv
// Purpose : scoreboard bench for comp_monitor_4bit against a behavioural model.
// Latency : expectations are pushed at drive time and popped one edge later.
// Backpress: none; the DUT presents fresh outputs after every clock edge.
module tb_comp_monitor_4bit;

  localparam int CNT_W    = 3;
  localparam int STABLE_N = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             HAB, CLR, IG, MA, ME;
  logic [CNT_W-1:0] CNT_IG, CNT_MA, CNT_ME;
  logic             TRAVA, ERRO, MUDOU;
`ifdef HIST_EN
  logic [7:0]       HIST;
`endif

  comp_monitor_4bit #(.CNT_W(CNT_W), .STABLE_N(STABLE_N)) dut (
    .CLK(CLK), .RST_N(RST_N), .HAB(HAB), .CLR(CLR),
    .IG(IG), .MA(MA), .ME(ME),
    .CNT_IG(CNT_IG), .CNT_MA(CNT_MA), .CNT_ME(CNT_ME),
    .TRAVA(TRAVA), .ERRO(ERRO), .MUDOU(MUDOU)
`ifdef HIST_EN
    , .HIST(HIST)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cig; int cma; int cme; int trava; int erro; int mudou; int hist;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: plain counts, a streak length of consecutive valid
  // equal results, the previous result, and a list of recent results.
  int m_cnt[4];      // indexed by code: 1=ME, 2=MA, 3=IG
  int m_err;
  int m_last;        // 0 means no previous result
  int m_streak;
  int m_mudou;
  int m_recent[$];   // newest first

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err = 0; m_last = 0; m_streak = 0; m_mudou = 0;
    m_recent.delete();
  endtask

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Drive one clock of stimulus, advance the model, queue the expectation.
  task automatic cycle(input bit hab, input bit clr, input bit ig, input bit ma, input bit me);
    exp_t e;
    int   code, h;
    @(negedge CLK);
    HAB = hab; CLR = clr; IG = ig; MA = ma; ME = me;
    m_mudou = 0;
    if (clr) begin
      model_reset();
    end else if (hab) begin
      if (int'(ig) + int'(ma) + int'(me) == 1) begin
        code = ig ? 3 : (ma ? 2 : 1);
        if (m_cnt[code] < CMAX) m_cnt[code]++;
        m_mudou = (m_last != 0 && m_last != code) ? 1 : 0;
        m_last = code;
        m_streak = (code == 3) ? m_streak + 1 : 0;
        m_recent.push_front(code);
        if (m_recent.size() > 4) void'(m_recent.pop_back());
      end else begin
        m_err = 1;
        m_streak = 0;
      end
    end
    h = 0;
    for (int i = 0; i < m_recent.size(); i++) h += m_recent[i] << (2 * i);
    e.cig = m_cnt[3]; e.cma = m_cnt[2]; e.cme = m_cnt[1];
    e.trava = (m_streak >= STABLE_N) ? 1 : 0;
    e.erro = m_err; e.mudou = m_mudou; e.hist = h;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(posedge CLK); #2; n++;
    end
    checks++;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d expected 0", sbq.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_CNT_IG"}, int'(CNT_IG), 0);
    cmp({tag, "_CNT_MA"}, int'(CNT_MA), 0);
    cmp({tag, "_CNT_ME"}, int'(CNT_ME), 0);
    cmp({tag, "_TRAVA"}, int'(TRAVA), 0);
    cmp({tag, "_ERRO"}, int'(ERRO), 0);
    cmp({tag, "_MUDOU"}, int'(MUDOU), 0);
`ifdef HIST_EN
    cmp({tag, "_HIST"}, int'(HIST), 0);
`endif
  endtask

  // Monitor: outputs are refreshed after each edge; compare one expectation per edge.
  always @(posedge CLK) begin
    #1;
    if (RST_N && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      cmp("CNT_IG", int'(CNT_IG), mon_e.cig);
      cmp("CNT_MA", int'(CNT_MA), mon_e.cma);
      cmp("CNT_ME", int'(CNT_ME), mon_e.cme);
      cmp("TRAVA", int'(TRAVA), mon_e.trava);
      cmp("ERRO", int'(ERRO), mon_e.erro);
      cmp("MUDOU", int'(MUDOU), mon_e.mudou);
`ifdef HIST_EN
      cmp("HIST", int'(HIST), mon_e.hist);
`endif
    end
  end

  initial begin
    int r;
    bit ig, ma, me;
    RST_N = 1'b0; HAB = 0; CLR = 0; IG = 0; MA = 0; ME = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

    // three MA samples
    repeat (3) cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    // four IG then one ME
    repeat (4) cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    // broken streak: IG IG MA IG IG IG
    cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0); cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0);
    // illegal combination, later valid samples, then clear
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 0); cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    // saturation, then clear with a simultaneous sample
    repeat (10) cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    // history pattern ME MA IG IG, then asynchronous reset between edges
    cycle(1, 0, 0, 0, 1); cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0);
    drain();
    @(negedge CLK);
    HAB = 0; CLR = 0;
    #2 RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();

    // randomized traffic biased toward equal results to reach lock
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      begin ig = 1; ma = 0; me = 0; end
      else if (r < 70) begin ig = 0; ma = 1; me = 0; end
      else if (r < 85) begin ig = 0; ma = 0; me = 1; end
      else begin ig = 1'($urandom); ma = 1'($urandom); me = 1'($urandom); end
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), ig, ma, me);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
